// File: rtl/bsort_pkg.sv
// Shared types and constants for the bubble sort controller and its index counter.
// BSORT_EARLY_EXIT_EN is consumed by bubble_sort_ctrl, not by this package.
package bsort_pkg;
   localparam int BSORT_N  = 32;
   localparam int BSORT_AW = 5;
   localparam int BSORT_DW = 8;

   localparam logic WR_SEL_D1 = 1'b0;
   localparam logic WR_SEL_D2 = 1'b1;

   typedef enum logic [3:0] {
      ST_IDLE = 4'd0,
      ST_INIT = 4'd1,
      ST_RD1  = 4'd2,
      ST_RD2  = 4'd3,
      ST_CMP  = 4'd4,
      ST_WR1  = 4'd5,
      ST_WR2  = 4'd6,
      ST_NEXT = 4'd7,
      ST_DONE = 4'd8
   } bsort_state_e;
endpackage

// File: rtl/bsort_idx_cnt.sv
// Pair index j and pass limit lim for the bubble sort controller.
// j+1 never wraps because j < lim <= N-1 is held by construction.
module bsort_idx_cnt
   import bsort_pkg::*;
#(
   parameter int N  = BSORT_N,
   parameter int AW = BSORT_AW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          inc,
   input  logic          pass_adv,
   output logic [AW-1:0] j,
   output logic [AW-1:0] j_inc,
   output logic          last_pair,
   output logic          last_pass
);
   localparam logic [AW-1:0] LIM_INIT = AW'(N - 1);
   localparam logic [AW-1:0] ONE      = AW'(1);

   logic [AW-1:0] j_r;
   logic [AW-1:0] lim_r;

   // Index/limit registers: clear at INIT, shrink lim at each pass end.
   always_ff @(posedge clk) begin
      if (!rst) begin
         j_r   <= {AW{1'b0}};
         lim_r <= {AW{1'b0}};
      end else if (clr) begin
         j_r   <= {AW{1'b0}};
         lim_r <= LIM_INIT;
      end else if (pass_adv) begin
         j_r   <= {AW{1'b0}};
         lim_r <= lim_r - ONE;
      end else if (inc) begin
         j_r   <= j_r + ONE;
      end else begin
         j_r   <= j_r;
         lim_r <= lim_r;
      end
   end

   assign j         = j_r;
   assign j_inc     = j_r + ONE;
   assign last_pair = (j_inc == lim_r);
   assign last_pass = (lim_r == ONE);
endmodule

// File: rtl/bubble_sort_ctrl.sv
// Control FSM for the in-place bubble sort engine (reads pairs, compares, swaps).
// Define BSORT_EARLY_EXIT_EN to finish as soon as a pass makes no swap.
module bubble_sort_ctrl
   import bsort_pkg::*;
#(
   parameter int N  = BSORT_N,
   parameter int AW = BSORT_AW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          cmp,
   output logic [AW-1:0] addr,
   output logic          read_mem,
   output logic          write_mem,
   output logic          ld_d1,
   output logic          ld_d2,
   output logic          wr_sel,
   output logic          busy,
   output logic          done,
   output logic [3:0]    ps
);
`ifdef BSORT_EARLY_EXIT_EN
   localparam logic EARLY_EXIT = 1'b1;
`else
   localparam logic EARLY_EXIT = 1'b0;
`endif

   bsort_state_e  state_r, state_nxt_s;
   logic          swapped_r, swapped_nxt_s;
   logic          clr_s, inc_s, pass_adv_s;
   logic [AW-1:0] j_s, j_inc_s;
   logic          last_pair_s, last_pass_s;

   bsort_idx_cnt #(.N(N), .AW(AW)) u_idx (
      .clk       (clk),
      .rst       (rst),
      .clr       (clr_s),
      .inc       (inc_s),
      .pass_adv  (pass_adv_s),
      .j         (j_s),
      .j_inc     (j_inc_s),
      .last_pair (last_pair_s),
      .last_pass (last_pass_s)
   );

   // State and swap-flag registers.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_r   <= ST_IDLE;
         swapped_r <= 1'b0;
      end else begin
         state_r   <= state_nxt_s;
         swapped_r <= swapped_nxt_s;
      end
   end

   // Next-state logic and counter controls.
   always_comb begin
      state_nxt_s   = state_r;
      swapped_nxt_s = swapped_r;
      clr_s         = 1'b0;
      inc_s         = 1'b0;
      pass_adv_s    = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (start) state_nxt_s = ST_INIT;
            else       state_nxt_s = ST_IDLE;
         end
         ST_INIT: begin
            clr_s         = 1'b1;
            swapped_nxt_s = 1'b0;
            state_nxt_s   = ST_RD1;
         end
         ST_RD1: state_nxt_s = ST_RD2;
         ST_RD2: state_nxt_s = ST_CMP;
         ST_CMP: begin
            // Strict greater-than only: equal keys stay put, keeping the sort stable.
            if (cmp) begin
               swapped_nxt_s = 1'b1;
               state_nxt_s   = ST_WR1;
            end else begin
               state_nxt_s   = ST_NEXT;
            end
         end
         ST_WR1: state_nxt_s = ST_WR2;
         ST_WR2: state_nxt_s = ST_NEXT;
         ST_NEXT: begin
            if (!last_pair_s) begin
               inc_s       = 1'b1;
               state_nxt_s = ST_RD1;
            end else if (last_pass_s || (EARLY_EXIT && !swapped_r)) begin
               state_nxt_s = ST_DONE;
            end else begin
               pass_adv_s    = 1'b1;
               swapped_nxt_s = 1'b0;
               state_nxt_s   = ST_RD1;
            end
         end
         ST_DONE: state_nxt_s = ST_IDLE;
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // Output decode from registered state and j only.
   always_comb begin
      addr      = {AW{1'b0}};
      read_mem  = 1'b0;
      write_mem = 1'b0;
      ld_d1     = 1'b0;
      ld_d2     = 1'b0;
      wr_sel    = WR_SEL_D1;
      done      = 1'b0;
      case (state_r)
         ST_RD1: begin
            addr     = j_s;
            read_mem = 1'b1;
            ld_d1    = 1'b1;
         end
         ST_RD2: begin
            addr     = j_inc_s;
            read_mem = 1'b1;
            ld_d2    = 1'b1;
         end
         ST_WR1: begin
            addr      = j_s;
            write_mem = 1'b1;
            wr_sel    = WR_SEL_D2;
         end
         ST_WR2: begin
            addr      = j_inc_s;
            write_mem = 1'b1;
            wr_sel    = WR_SEL_D1;
         end
         ST_DONE: done = 1'b1;
         default: done = 1'b0;
      endcase
   end

   assign busy = (state_r != ST_IDLE);
   assign ps   = state_r;
endmodule
